pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
- Sits between the SPI register decode and the PWM channel registers inside Main.
- Holds a per-channel target duty and step size, and ramps each channel's active duty toward its target on a prescaled tick.
- Services channels round-robin over a single shared write port into the PWM register bank, giving glitch-free fades on the open-drain outputs.

Parameters:
- NUM_CH, 4, number of PWM channels serviced; power of two, at least 2.
- DUTY_W, 8, duty value width in bits.
- PRESC_W, 16, width of the tick prescaler divisor.

Ports:
- CLK  input  1  MainCLK domain clock. Config inputs are already synchronized to this domain.
- RST  input  1  asynchronous reset, active-high.
- EN  input  1  active-high. When low, the prescaler holds and no new ticks are generated. A sweep already in progress completes.
- cfg_we  input  1  single-cycle write strobe for the channel's target and step.
- cfg_ch  input  log2(NUM_CH)  channel selected by cfg_we.
- cfg_target  input  DUTY_W  target duty for cfg_ch.
- cfg_step  input  DUTY_W  ramp increment per tick. 0 means jump directly to target.
- rate_div  input  PRESC_W  tick period minus 1, in CLK cycles.
- pwm_we  output  1  write strobe to the PWM register bank.
- pwm_ch  output  log2(NUM_CH)  channel written.
- pwm_duty  output  DUTY_W  new duty for pwm_ch.
- busy  output  1  high while a sweep is in progress.
- settled  output  NUM_CH  bit k high when current[k] equals target[k].
- overrun  output  1  sticky; set when a tick is dropped.

Behaviour:
- Reset (asynchronous, immediate, including mid-sweep):
  - current[], target[] and step[] = 0; prescaler = 0; state = IDLE.
  - pwm_we = 0, pwm_ch = 0, pwm_duty = 0, busy = 0, settled = all 1s, overrun = 0.
- Prescaler:
  - Counts 0..rate_div while EN is high and asserts an internal tick when count == rate_div, then wraps to 0. rate_div = 0 gives a tick every cycle.
  - If rate_div is changed to a value below the current count, the counter wraps to 0 without a tick.
- FSM:
  - IDLE -> SWEEP on tick, or on pending when idle.
  - SWEEP: idx runs 0..NUM_CH-1, one channel per cycle. SWEEP -> IDLE after idx = NUM_CH-1 unless pending is set, in which case go to SWEEP again with idx = 0 and clear pending.
- Tick during SWEEP:
  - Sets a one-deep pending flag.
  - A tick while pending is already set is dropped and sets overrun, which stays set until RST.
- Per-channel decision (cycle where idx = k):
  - If current[k] == target[k]: no write.
  - Else compute next with (DUTY_W+1)-bit difference arithmetic:
    - step = 0: next = target.
    - Rising: next = target if target - current <= step, else current + step.
    - Falling: next = target if current - target <= step, else current - step.
  - current[k] <= next.
  - Registered write: pwm_we = 1, pwm_ch = k, pwm_duty = next in the following cycle.
  - Result never overshoots and never wraps.
- Timing: for a tick in cycle T, the write for channel k appears in cycle T+2+k. At most one pwm_we per cycle. pwm_we is low otherwise; pwm_ch and pwm_duty hold their last values.
- cfg_we:
  - Updates target and step in the same cycle.
  - Decisions use the registered values, so a write in cycle N affects decisions from cycle N+1.
  - A write to the channel being decided in cycle N does not alter that cycle's result.
- busy = (state == SWEEP), registered.
- settled[k] is registered and updates the cycle after current or target changes.
- EN low mid-sweep: the sweep completes and pending is still honoured. Only the prescaler freezes.

Decomposition:
- Shared package pwm_io_pkg:
  - NUM_CH, DUTY_W and PRESC_W defaults.
  - Channel index width constant.
  - FSM state enum {IDLE, SWEEP}.
- Sub-module pwm_tick_prescaler (CLK, RST, EN, rate_div -> tick).
- Ramp arithmetic, state and arrays live in pwm_ramp_sequencer.

Test Plan:
- Ramp up: rate_div = 9, target[0] = 20, step[0] = 8 -> pwm_duty on ch0 writes 8, 16, 20 at 10-cycle spacing, each at T+2. settled[0] rises after the third write, then no further ch0 writes.
- Jump and ordering: step[2] = 0, target[2] = 200, target[1] = 5, step[1] = 5 -> in one sweep, ch1 = 5 at T+3 and ch2 = 200 at T+4. Channels 0 and 3 are not written.
- Ramp down near zero: current[3] = 3, target[3] = 0, step[3] = 8 -> a single write of 0, no wrap to 251.
- Overrun: rate_div = 0 with NUM_CH = 4 -> pending is taken, then the next tick sets overrun = 1, which stays set. busy remains high continuously.
- Config collision: cfg_we to ch1 in the same cycle idx = 1 -> that cycle uses the old target, and the new target is applied on the next sweep.
- Reset mid-sweep: assert RST during idx = 2 -> outputs go to reset values immediately. After release, no pwm_we occurs until a new tick and cfg.

Source files
------------

// File: rtl/pwm_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_io_pkg
//  Purpose  : Shared constants and types for the PWM ramp sequencer slice.
//             It holds the default channel count and widths, the channel index
//             width helper, and the sequencer FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package pwm_io_pkg;

    localparam int PWM_NUM_CH  = 4;
    localparam int PWM_DUTY_W  = 8;
    localparam int PWM_PRESC_W = 16;

    // The index width is kept at a minimum of 1 so that a channel
    // select port always exists.
    function automatic int ch_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int PWM_CH_W = ch_idx_w(PWM_NUM_CH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } seq_state_t;

endpackage : pwm_io_pkg
`default_nettype wire

// File: rtl/pwm_ramp_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_ramp_sequencer_if
//  Purpose  : Bundles the sequencer configuration inputs and the PWM register
//             bank write port.
//  Ports    : master - drives EN, cfg_*, rate_div; observes pwm_*, busy,
//                      settled, overrun (SPI decode side / testbench)
//             slave  - the sequencer itself
//  Revision : 1.0  initial release
// ============================================================================
interface pwm_ramp_sequencer_if
    import pwm_io_pkg::*;
#(
    parameter int NUM_CH  = PWM_NUM_CH,
    parameter int DUTY_W  = PWM_DUTY_W,
    parameter int PRESC_W = PWM_PRESC_W
);
    localparam int CH_W = ch_idx_w(NUM_CH);

    // configuration side
    logic                EN;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [DUTY_W-1:0]   cfg_target;
    logic [DUTY_W-1:0]   cfg_step;
    logic [PRESC_W-1:0]  rate_div;

    // PWM register bank write port and status
    logic                pwm_we;
    logic [CH_W-1:0]     pwm_ch;
    logic [DUTY_W-1:0]   pwm_duty;
    logic                busy;
    logic [NUM_CH-1:0]   settled;
    logic                overrun;

    modport master (
        output EN, cfg_we, cfg_ch, cfg_target, cfg_step, rate_div,
        input  pwm_we, pwm_ch, pwm_duty, busy, settled, overrun
    );

    modport slave (
        input  EN, cfg_we, cfg_ch, cfg_target, cfg_step, rate_div,
        output pwm_we, pwm_ch, pwm_duty, busy, settled, overrun
    );

endinterface : pwm_ramp_sequencer_if
`default_nettype wire

// File: rtl/pwm_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_tick_prescaler
//  Purpose  : Divides CLK down to the ramp tick. The counter runs 0..rate_div
//             while EN is high and pulses tick for one cycle when it reaches
//             rate_div. With EN low the counter holds its value.
//  Ports    : CLK, RST (async, active-high), EN, rate_div -> tick
//  Revision : 1.0  initial release
// ============================================================================
module pwm_tick_prescaler #(
    parameter int PRESC_W = 16
) (
    input  wire logic               CLK,
    input  wire logic               RST,
    input  wire logic               EN,
    input  wire logic [PRESC_W-1:0] rate_div,
    output logic                    tick
);

    logic [PRESC_W-1:0] count_q;
    logic [PRESC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (EN) begin
            if (count_q == rate_div) begin
                tick    = 1'b1;
                count_d = '0;
            end else if (count_q > rate_div) begin
                // rate_div was lowered below the running count: restart the
                // period silently rather than emitting a spurious tick.
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : pwm_tick_prescaler
`default_nettype wire

// File: rtl/pwm_ramp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_ramp_sequencer
//  Purpose  : Holds per-channel target duty and step size and ramps each
//             channel's active duty toward its target once per prescaled tick.
//             Channels are serviced round-robin, one per cycle, over a single
//             registered write port into the PWM register bank.
//  Ports    : CLK           clock
//             RST           asynchronous reset, active-high
//             bus (slave)   EN, cfg_we/cfg_ch/cfg_target/cfg_step, rate_div in;
//                           pwm_we/pwm_ch/pwm_duty, busy, settled, overrun out
//  Revision : 1.0  initial release
// ============================================================================
module pwm_ramp_sequencer
    import pwm_io_pkg::*;
#(
    parameter int NUM_CH  = PWM_NUM_CH,
    parameter int DUTY_W  = PWM_DUTY_W,
    parameter int PRESC_W = PWM_PRESC_W
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    pwm_ramp_sequencer_if.slave bus
);

    localparam int              CH_W     = ch_idx_w(NUM_CH);
    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_t          state_q,   state_d;
    logic [CH_W-1:0]     idx_q,     idx_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic                busy_q,    busy_d;
    logic [NUM_CH-1:0]   settled_q, settled_d;
    logic                pwm_we_q,  pwm_we_d;
    logic [CH_W-1:0]     pwm_ch_q,  pwm_ch_d;
    logic [DUTY_W-1:0]   pwm_duty_q, pwm_duty_d;

    logic [DUTY_W-1:0]   current_q [NUM_CH];
    logic [DUTY_W-1:0]   current_d [NUM_CH];
    logic [DUTY_W-1:0]   target_q  [NUM_CH];
    logic [DUTY_W-1:0]   target_d  [NUM_CH];
    logic [DUTY_W-1:0]   step_q    [NUM_CH];
    logic [DUTY_W-1:0]   step_d    [NUM_CH];

    logic                w_tick;

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    pwm_tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (bus.EN),
        .rate_div (bus.rate_div),
        .tick     (w_tick)
    );

    // ------------------------------------------------------------------
    // Ramp arithmetic for the channel under idx_q
    // ------------------------------------------------------------------
    logic [DUTY_W-1:0] w_cur;
    logic [DUTY_W-1:0] w_tgt;
    logic [DUTY_W-1:0] w_stp;
    logic [DUTY_W-1:0] w_next;
    logic [DUTY_W:0]   w_diff_up;
    logic [DUTY_W:0]   w_diff_dn;
    logic [DUTY_W:0]   w_step_x;
    logic              w_need;

    always_comb begin
        w_cur     = current_q[idx_q];
        w_tgt     = target_q[idx_q];
        w_stp     = step_q[idx_q];
        // One extra bit keeps the distance comparison free of wrap-around.
        w_diff_up = {1'b0, w_tgt} - {1'b0, w_cur};
        w_diff_dn = {1'b0, w_cur} - {1'b0, w_tgt};
        w_step_x  = {1'b0, w_stp};
        w_need    = (w_cur != w_tgt);

        if (w_stp == '0) begin
            w_next = w_tgt;
        end else if (w_tgt > w_cur) begin
            // distance > step guarantees cur + step < tgt, so no overflow
            w_next = (w_diff_up <= w_step_x) ? w_tgt : (w_cur + w_stp);
        end else begin
            // distance > step guarantees cur - step > tgt, so no underflow
            w_next = (w_diff_dn <= w_step_x) ? w_tgt : (w_cur - w_stp);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        pwm_we_d   = 1'b0;
        pwm_ch_d   = pwm_ch_q;
        pwm_duty_d = pwm_duty_q;
        current_d  = current_q;
        target_d   = target_q;
        step_d     = step_q;

        // Config lands in the registered arrays; the decision for this
        // cycle already used the old contents through w_* above.
        if (bus.cfg_we) begin
            target_d[bus.cfg_ch] = bus.cfg_target;
            step_d[bus.cfg_ch]   = bus.cfg_step;
        end

        case (state_q)
            IDLE: begin
                if (w_tick || pending_q) begin
                    state_d   = SWEEP;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end

            SWEEP: begin
                if (w_need) begin
                    current_d[idx_q] = w_next;
                    pwm_we_d         = 1'b1;
                    pwm_ch_d         = idx_q;
                    pwm_duty_d       = w_next;
                end

                // Only one tick can be queued behind the running sweep.
                if (w_tick) begin
                    if (pending_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end

                if (idx_q == LAST_IDX) begin
                    if (pending_q) begin
                        idx_d     = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SWEEP);

        for (int k = 0; k < NUM_CH; k++) begin
            settled_d[k] = (current_q[k] == target_q[k]);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            settled_q  <= '1;
            pwm_we_q   <= 1'b0;
            pwm_ch_q   <= '0;
            pwm_duty_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                current_q[k] <= '0;
                target_q[k]  <= '0;
                step_q[k]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            settled_q  <= settled_d;
            pwm_we_q   <= pwm_we_d;
            pwm_ch_q   <= pwm_ch_d;
            pwm_duty_q <= pwm_duty_d;
            current_q  <= current_d;
            target_q   <= target_d;
            step_q     <= step_d;
        end
    end

    assign bus.pwm_we   = pwm_we_q;
    assign bus.pwm_ch   = pwm_ch_q;
    assign bus.pwm_duty = pwm_duty_q;
    assign bus.busy     = busy_q;
    assign bus.settled  = settled_q;
    assign bus.overrun  = overrun_q;

endmodule : pwm_ramp_sequencer
`default_nettype wire

// File: tb/tb_pwm_ramp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_ramp_sequencer
//  Purpose  : Directed self-checking bench for pwm_ramp_sequencer. Every
//             write to the PWM bank is logged with its cycle number; each
//             scenario task compares the log and status outputs against
//             hand-computed values. Cycle numbers are relative to the cycle
//             in which EN is raised (prescaler count 0 in that cycle).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_ramp_sequencer;

    localparam int NUM_CH  = 4;
    localparam int DUTY_W  = 8;
    localparam int PRESC_W = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int cyc;
        int ch;
        int duty;
    } ev_t;

    ev_t evq[$];
    ev_t mon_ev;

    pwm_ramp_sequencer_if #(
        .NUM_CH  (NUM_CH),
        .DUTY_W  (DUTY_W),
        .PRESC_W (PRESC_W)
    ) bus ();

    pwm_ramp_sequencer #(
        .NUM_CH  (NUM_CH),
        .DUTY_W  (DUTY_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every bank write, sampled mid-cycle.
    always @(negedge CLK) begin
        if (bus.pwm_we === 1'b1) begin
            mon_ev.cyc  = cyc;
            mon_ev.ch   = int'(bus.pwm_ch);
            mon_ev.duty = int'(bus.pwm_duty);
            evq.push_back(mon_ev);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        RST            = 1'b1;
        bus.EN         = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_target = '0;
        bus.cfg_step   = '0;
        bus.rate_div   = '0;
        step();
        step();
        RST = 1'b0;
        step();
        evq.delete();
    endtask

    task automatic cfg(input int ch, input int tgt, input int stp);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 2'(ch);
        bus.cfg_target = 8'(tgt);
        bus.cfg_step   = 8'(stp);
        step();
        bus.cfg_we     = 1'b0;
    endtask

    task automatic start(input int rd, output int e);
        bus.rate_div = 16'(rd);
        bus.EN       = 1'b1;
        e            = cyc;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++; if (bus.pwm_we !== 1'b0) begin errors++; $display("FAIL reset_pwm_we got %b want 0", bus.pwm_we); end
        checks++; if (bus.pwm_ch !== 2'd0) begin errors++; $display("FAIL reset_pwm_ch got %0d want 0", bus.pwm_ch); end
        checks++; if (bus.pwm_duty !== 8'd0) begin errors++; $display("FAIL reset_pwm_duty got %0d want 0", bus.pwm_duty); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.settled !== 4'hF) begin errors++; $display("FAIL reset_settled got %h want f", bus.settled); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ramp_up();
        int e;
        int exp_c[3];
        int exp_d[3];
        do_reset();
        cfg(0, 20, 8);
        start(9, e);
        exp_c = '{e + 11, e + 21, e + 31};
        exp_d = '{8, 16, 20};
        wait_until(e + 12);
        checks++; if (bus.pwm_we !== 1'b0 || bus.pwm_duty !== 8'd8 || bus.pwm_ch !== 2'd0) begin
            errors++; $display("FAIL ramp_hold got we=%b ch=%0d duty=%0d want we=0 ch=0 duty=8", bus.pwm_we, bus.pwm_ch, bus.pwm_duty);
        end
        wait_until(e + 31);
        checks++; if (bus.settled[0] !== 1'b0) begin errors++; $display("FAIL ramp_settled_early got %b want 0", bus.settled[0]); end
        wait_until(e + 32);
        checks++; if (bus.settled[0] !== 1'b1) begin errors++; $display("FAIL ramp_settled got %b want 1", bus.settled[0]); end
        wait_until(e + 60);
        bus.EN = 1'b0;
        checks++; if (evq.size() !== 3) begin errors++; $display("FAIL ramp_count got %0d want 3", evq.size()); end
        for (int i = 0; i < 3 && i < evq.size(); i++) begin
            checks++;
            if (evq[i].cyc !== exp_c[i] || evq[i].ch !== 0 || evq[i].duty !== exp_d[i]) begin
                errors++;
                $display("FAIL ramp_write%0d got cyc=%0d ch=%0d duty=%0d want cyc=%0d ch=0 duty=%0d",
                         i, evq[i].cyc - e, evq[i].ch, evq[i].duty, exp_c[i] - e, exp_d[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_jump_order();
        int e;
        int exp_c[2];
        int exp_h[2];
        int exp_d[2];
        do_reset();
        cfg(2, 200, 0);
        cfg(1, 5, 5);
        start(9, e);
        exp_c = '{e + 12, e + 13};
        exp_h = '{1, 2};
        exp_d = '{5, 200};
        wait_until(e + 40);
        bus.EN = 1'b0;
        checks++; if (evq.size() !== 2) begin errors++; $display("FAIL jump_count got %0d want 2", evq.size()); end
        for (int i = 0; i < 2 && i < evq.size(); i++) begin
            checks++;
            if (evq[i].cyc !== exp_c[i] || evq[i].ch !== exp_h[i] || evq[i].duty !== exp_d[i]) begin
                errors++;
                $display("FAIL jump_write%0d got cyc=%0d ch=%0d duty=%0d want cyc=%0d ch=%0d duty=%0d",
                         i, evq[i].cyc - e, evq[i].ch, evq[i].duty, exp_c[i] - e, exp_h[i], exp_d[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ramp_down();
        int e;
        int exp_c[2];
        int exp_d[2];
        do_reset();
        cfg(3, 3, 0);
        start(9, e);
        wait_until(e + 15);
        cfg(3, 0, 8);
        exp_c = '{e + 14, e + 24};
        exp_d = '{3, 0};
        wait_until(e + 50);
        bus.EN = 1'b0;
        checks++; if (bus.settled[3] !== 1'b1) begin errors++; $display("FAIL down_settled got %b want 1", bus.settled[3]); end
        checks++; if (evq.size() !== 2) begin errors++; $display("FAIL down_count got %0d want 2", evq.size()); end
        for (int i = 0; i < 2 && i < evq.size(); i++) begin
            checks++;
            if (evq[i].cyc !== exp_c[i] || evq[i].ch !== 3 || evq[i].duty !== exp_d[i]) begin
                errors++;
                $display("FAIL down_write%0d got cyc=%0d ch=%0d duty=%0d want cyc=%0d ch=3 duty=%0d",
                         i, evq[i].cyc - e, evq[i].ch, evq[i].duty, exp_c[i] - e, exp_d[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_overrun();
        int e;
        int drops;
        do_reset();
        start(0, e);
        wait_until(e + 2);
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", bus.overrun); end
        wait_until(e + 3);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", bus.overrun); end
        drops = 0;
        wait_until(e + 1);
        for (int c = 0; c < 20; c++) begin
            if (bus.busy !== 1'b1) drops++;
            step();
        end
        checks++; if (drops !== 0) begin errors++; $display("FAIL ovr_busy_cont got %0d low cycles want 0", drops); end
        bus.EN = 1'b0;
        wait_until(e + 45);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ovr_idle_busy got %b want 0", bus.busy); end
        checks++; if (evq.size() !== 0) begin errors++; $display("FAIL ovr_writes got %0d want 0", evq.size()); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_cfg_collision();
        int e;
        int exp_c[2];
        int exp_d[2];
        do_reset();
        cfg(1, 10, 0);
        start(9, e);
        wait_until(e + 11);
        cfg(1, 50, 0);
        exp_c = '{e + 12, e + 22};
        exp_d = '{10, 50};
        wait_until(e + 45);
        bus.EN = 1'b0;
        checks++; if (evq.size() !== 2) begin errors++; $display("FAIL coll_count got %0d want 2", evq.size()); end
        for (int i = 0; i < 2 && i < evq.size(); i++) begin
            checks++;
            if (evq[i].cyc !== exp_c[i] || evq[i].ch !== 1 || evq[i].duty !== exp_d[i]) begin
                errors++;
                $display("FAIL coll_write%0d got cyc=%0d ch=%0d duty=%0d want cyc=%0d ch=1 duty=%0d",
                         i, evq[i].cyc - e, evq[i].ch, evq[i].duty, exp_c[i] - e, exp_d[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_sweep();
        int e;
        do_reset();
        for (int k = 0; k < NUM_CH; k++) cfg(k, 100 + k, 0);
        start(9, e);
        wait_until(e + 12);
        checks++; if (bus.pwm_we !== 1'b1 || bus.pwm_ch !== 2'd1 || bus.pwm_duty !== 8'd101) begin
            errors++; $display("FAIL mid_pre got we=%b ch=%0d duty=%0d want we=1 ch=1 duty=101", bus.pwm_we, bus.pwm_ch, bus.pwm_duty);
        end
        RST = 1'b1;
        #1;
        checks++; if (bus.pwm_we !== 1'b0) begin errors++; $display("FAIL mid_pwm_we got %b want 0", bus.pwm_we); end
        checks++; if (bus.pwm_ch !== 2'd0) begin errors++; $display("FAIL mid_pwm_ch got %0d want 0", bus.pwm_ch); end
        checks++; if (bus.pwm_duty !== 8'd0) begin errors++; $display("FAIL mid_pwm_duty got %0d want 0", bus.pwm_duty); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bus.busy); end
        checks++; if (bus.settled !== 4'hF) begin errors++; $display("FAIL mid_settled got %h want f", bus.settled); end
        step();
        step();
        RST = 1'b0;
        evq.delete();
        e = cyc;
        wait_until(e + 40);
        bus.EN = 1'b0;
        checks++; if (evq.size() !== 0) begin errors++; $display("FAIL mid_after_writes got %0d want 0", evq.size()); end
        checks++; if (bus.settled !== 4'hF) begin errors++; $display("FAIL mid_after_settled got %h want f", bus.settled); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        bus.EN         = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_target = '0;
        bus.cfg_step   = '0;
        bus.rate_div   = '0;
        test_reset();
        test_ramp_up();
        test_jump_order();
        test_ramp_down();
        test_overrun();
        test_cfg_collision();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pwm_ramp_sequencer
`default_nettype wire
